// File: rtl/mem_pkg.sv
// Shared definitions for the memory bus initiator: state codes, access sizes,
// the latched request record and the alignment rule.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD      = 3'd1;
    localparam logic [2:0] ST_WSETUP  = 3'd2;
    localparam logic [2:0] ST_WSTROBE = 3'd3;
    localparam logic [2:0] ST_WHOLD   = 3'd4;
    localparam logic [2:0] ST_RESP    = 3'd5;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        sign_ext;
        logic [1:0]  addr_lo;
        logic [31:0] wdata;
    } req_t;

    // Size encoding 3 is reserved, so it always faults.
    function automatic logic align_fault(input logic [1:0] size, input logic [1:0] addr_lo);
        logic f;
        case (size)
            SZ_BYTE: f = 1'b0;
            SZ_HALF: f = addr_lo[0];
            SZ_WORD: f = |addr_lo;
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/mem_if.sv
// Strobed memory bus between the initiator and the MMU.
interface mem_if;
    logic [31:0] ADDR;
    logic        N_OE;
    logic        N_WE;
    logic [31:0] BUS_OUT;
    logic [31:0] BUS_IN;

    modport master (output ADDR, output N_OE, output N_WE, output BUS_OUT, input BUS_IN);
    modport slave  (input ADDR, input N_OE, input N_WE, input BUS_OUT, output BUS_IN);
endinterface

// File: rtl/mem_lane.sv
// Byte/halfword lane steering: extracts and extends a load value from a word,
// and merges store data into the addressed lane of a word.
module mem_lane
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it
        // unassigned; a missing default here would infer a latch.
        byte_v     = word[{addr_lo, 3'b000} +: 8];
        half_v     = word[{addr_lo[1], 4'b0000} +: 16];
        load_val   = word;
        store_word = word;
        case (size)
            SZ_BYTE: begin
                load_val = sign_ext ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_val = sign_ext ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_WORD: store_word = wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_master.sv
// Single-outstanding bus initiator: sequences N_OE/N_WE with setup/strobe/hold,
// does read-modify-write for sub-word stores and reports misaligned requests.
module mem_master
    import mem_pkg::*;
#(
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic        CLK,
    input  logic        N_RST,
    input  logic        REQ,
    input  logic        WRITE,
    input  logic [1:0]  SIZE,
    input  logic        SIGNED,
    input  logic [31:0] REQ_ADDR,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        FAULT,
    output logic [31:0] RDATA,
    mem_if.master       bus
);

    localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    req_t             req_q;
    logic [31:0]      addr_q;
    logic [31:0]      bus_out_q;
    logic [31:0]      rdata_q;
    logic             n_oe_q;
    logic             n_we_q;
    logic             done_q;
    logic             fault_q;
    logic [31:0]      load_val;
    logic [31:0]      store_word;

    mem_lane u_lane (
        .word       (bus.BUS_IN),
        .addr_lo    (req_q.addr_lo),
        .size       (req_q.size),
        .sign_ext   (req_q.sign_ext),
        .wdata      (req_q.wdata),
        .load_val   (load_val),
        .store_word (store_word)
    );

    // NOTE: all state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_q     <= '0;
            addr_q    <= '0;
            bus_out_q <= '0;
            rdata_q   <= '0;
            n_oe_q    <= 1'b1;
            n_we_q    <= 1'b1;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ) begin
                        req_q <= '{write: WRITE, size: SIZE, sign_ext: SIGNED,
                                   addr_lo: REQ_ADDR[1:0], wdata: WDATA};
                        if (align_fault(SIZE, REQ_ADDR[1:0])) begin
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                            state   <= ST_RESP;
                        end else begin
                            addr_q <= {REQ_ADDR[31:2], 2'b00};
                            if (WRITE && SIZE == SZ_WORD) begin
                                bus_out_q <= WDATA;
                                state     <= ST_WSETUP;
                            end else begin
                                // Loads and sub-word stores both start by reading the word.
                                n_oe_q <= 1'b0;
                                cnt    <= RD_LOAD;
                                state  <= ST_RD;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (cnt == '0) begin
                        n_oe_q <= 1'b1;
                        if (req_q.write) begin
                            bus_out_q <= store_word;
                            state     <= ST_WSETUP;
                        end else begin
                            rdata_q <= load_val;
                            done_q  <= 1'b1;
                            state   <= ST_RESP;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WSETUP: begin
                    n_we_q <= 1'b0;
                    cnt    <= WR_LOAD;
                    state  <= ST_WSTROBE;
                end
                ST_WSTROBE: begin
                    if (cnt == '0) begin
                        n_we_q <= 1'b1;
                        done_q <= 1'b1;
                        state  <= ST_WHOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WHOLD, ST_RESP: state <= ST_IDLE;
                default: begin
                    n_oe_q <= 1'b1;
                    n_we_q <= 1'b1;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY        = (state != ST_IDLE);
    assign DONE        = done_q;
    assign FAULT       = fault_q;
    assign RDATA       = rdata_q;
    assign bus.ADDR    = addr_q;
    assign bus.N_OE    = n_oe_q;
    assign bus.N_WE    = n_we_q;
    assign bus.BUS_OUT = bus_out_q;

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master: dut 0 uses READ_WAIT=WRITE_WAIT=1, dut 1 uses 2/2.
module tb_mem_master;

    logic        CLK = 1'b0;
    logic        N_RST;
    logic [1:0]  req, wr, sgn;
    logic [1:0]  size_v   [2];
    logic [31:0] addr_v   [2];
    logic [31:0] wdata_v  [2];
    logic [31:0] bus_in_v [2];

    wire  [1:0]  busy, done, fault, n_oe, n_we;
    wire  [31:0] rdata   [2];
    wire  [31:0] oaddr   [2];
    wire  [31:0] bus_out [2];

    mem_if bus_a ();
    mem_if bus_b ();

    assign bus_a.BUS_IN = bus_in_v[0];
    assign bus_b.BUS_IN = bus_in_v[1];
    assign oaddr[0]   = bus_a.ADDR;    assign oaddr[1]   = bus_b.ADDR;
    assign bus_out[0] = bus_a.BUS_OUT; assign bus_out[1] = bus_b.BUS_OUT;
    assign n_oe[0]    = bus_a.N_OE;    assign n_oe[1]    = bus_b.N_OE;
    assign n_we[0]    = bus_a.N_WE;    assign n_we[1]    = bus_b.N_WE;

    mem_master #(.READ_WAIT(1), .WRITE_WAIT(1)) dut_a (
        .CLK(CLK), .N_RST(N_RST), .REQ(req[0]), .WRITE(wr[0]), .SIZE(size_v[0]),
        .SIGNED(sgn[0]), .REQ_ADDR(addr_v[0]), .WDATA(wdata_v[0]), .BUSY(busy[0]),
        .DONE(done[0]), .FAULT(fault[0]), .RDATA(rdata[0]), .bus(bus_a.master)
    );

    mem_master #(.READ_WAIT(2), .WRITE_WAIT(2)) dut_b (
        .CLK(CLK), .N_RST(N_RST), .REQ(req[1]), .WRITE(wr[1]), .SIZE(size_v[1]),
        .SIGNED(sgn[1]), .REQ_ADDR(addr_v[1]), .WDATA(wdata_v[1]), .BUSY(busy[1]),
        .DONE(done[1]), .FAULT(fault[1]), .RDATA(rdata[1]), .bus(bus_b.master)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          d;
        bit          wr;
        bit          fault;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          oe;
        int          we;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] rdata_model [2];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_cyc  [2];
    int          oe_cnt   [2];
    int          we_cnt   [2];
    int          serr     [2];
    int          done_cnt [2];
    bit          prev_oe_low [2];
    bit          prev_we_low [2];
    bit          after_done  [2];

    // Monitor: strobe bookkeeping per transaction, DONE pops the scoreboard.
    always @(negedge CLK) begin
        if (!N_RST) begin
            for (int d = 0; d < 2; d++) begin
                prev_oe_low[d] = 1'b0;
                prev_we_low[d] = 1'b0;
                after_done[d]  = 1'b0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (after_done[d]) begin
                    after_done[d] = 1'b0;
                    n_cmp++;
                    if (busy[d] !== 1'b0) begin
                        n_bad++;
                        $display("FAIL idle_after_done: dut%0d BUSY=%b expected 0", d, busy[d]);
                    end
                end
                if (!n_oe[d]) oe_cnt[d]++;
                if (!n_we[d]) we_cnt[d]++;
                if (!n_oe[d] || !n_we[d]) begin
                    if (!n_oe[d] && !n_we[d]) serr[d]++;
                    if ((!n_we[d] && prev_oe_low[d]) || (!n_oe[d] && prev_we_low[d])) serr[d]++;
                    if (sb_q.size() == 0) serr[d]++;
                    else begin
                        if (oaddr[d] !== sb_q[0].addr) serr[d]++;
                        if (!n_we[d] && bus_out[d] !== sb_q[0].wdata) serr[d]++;
                    end
                end
                if (fault[d] && !done[d]) serr[d]++;
                prev_oe_low[d] = !n_oe[d];
                prev_we_low[d] = !n_we[d];

                if (done[d]) begin
                    done_cnt[d]++;
                    after_done[d] = 1'b1;
                    n_cmp++;
                    if (sb_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_done: dut%0d DONE=1 with no request outstanding", d);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        if (e.d != d) begin
                            n_bad++;
                            $display("FAIL done_source: dut%0d completed, expected dut%0d", d, e.d);
                        end
                        n_cmp++;
                        if (fault[d] !== e.fault) begin
                            n_bad++;
                            $display("FAIL fault: dut%0d got %b expected %b", d, fault[d], e.fault);
                        end
                        n_cmp++;
                        if (cyc - acc_cyc[d] != e.lat) begin
                            n_bad++;
                            $display("FAIL latency: dut%0d got %0d expected %0d", d, cyc - acc_cyc[d], e.lat);
                        end
                        n_cmp++;
                        if (oe_cnt[d] != e.oe || we_cnt[d] != e.we) begin
                            n_bad++;
                            $display("FAIL strobe_cycles: dut%0d got oe=%0d we=%0d expected oe=%0d we=%0d",
                                     d, oe_cnt[d], we_cnt[d], e.oe, e.we);
                        end
                        n_cmp++;
                        if (serr[d] != 0) begin
                            n_bad++;
                            $display("FAIL bus_protocol: dut%0d got %0d violations expected 0", d, serr[d]);
                        end
                        n_cmp++;
                        if (busy[d] !== 1'b1) begin
                            n_bad++;
                            $display("FAIL busy_at_done: dut%0d got %b expected 1", d, busy[d]);
                        end
                        if (!e.wr || e.fault) begin
                            n_cmp++;
                            if (rdata[d] !== e.rdata) begin
                                n_bad++;
                                $display("FAIL rdata: dut%0d got %h expected %h", d, rdata[d], e.rdata);
                            end
                        end
                    end
                end

                if (!busy[d] && req[d]) begin
                    acc_cyc[d] = cyc;
                    oe_cnt[d]  = 0;
                    we_cnt[d]  = 0;
                    serr[d]    = 0;
                end
            end
        end
    end

    task automatic push_exp(input int d, input bit w, input bit f, input logic [31:0] r,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int lat, input int oe, input int we);
        exp_t e;
        e.d = d; e.wr = w; e.fault = f; e.addr = a; e.wdata = wd;
        e.lat = lat; e.oe = oe; e.we = we;
        e.rdata = f ? rdata_model[d] : r;
        if (!w && !f) rdata_model[d] = r;
        sb_q.push_back(e);
    endtask

    task automatic set_inputs(input int d, input bit w, input logic [1:0] sz, input bit sg,
                              input logic [31:0] a, input logic [31:0] wd);
        wr[d] = w; size_v[d] = sz; sgn[d] = sg; addr_v[d] = a; wdata_v[d] = wd;
    endtask

    task automatic wait_done(input int d, input int target, input int budget);
        int n = 0;
        while (done_cnt[d] < target && n < budget) begin
            @(negedge CLK); #1;
            n++;
        end
        if (done_cnt[d] < target) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: dut%0d got %0d completions expected %0d", d, done_cnt[d], target);
        end
    endtask

    // One request: expectation pushed as REQ is driven, then wait for its DONE.
    task automatic run(input int d, input bit w, input logic [1:0] sz, input bit sg,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] bi,
                       input bit f, input logic [31:0] r, input logic [31:0] ea,
                       input logic [31:0] ewd, input int lat, input int oe, input int we);
        int start = done_cnt[d];
        push_exp(d, w, f, r, ea, ewd, lat, oe, we);
        @(posedge CLK); #1;
        bus_in_v[d] = bi;
        set_inputs(d, w, sz, sg, a, wd);
        req[d] = 1'b1;
        @(posedge CLK); #1;
        req[d] = 1'b0;
        wait_done(d, start + 1, 30);
    endtask

    task automatic test_reset;
        N_RST = 1'b0;
        req = '0; wr = '0; sgn = '0;
        for (int d = 0; d < 2; d++) begin
            size_v[d] = '0; addr_v[d] = '0; wdata_v[d] = '0; bus_in_v[d] = '0;
            rdata_model[d] = '0; done_cnt[d] = 0; acc_cyc[d] = 0;
            oe_cnt[d] = 0; we_cnt[d] = 0; serr[d] = 0;
        end
        #12;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if ({n_oe[d], n_we[d], busy[d], done[d], fault[d]} !== 5'b11000) begin
                n_bad++;
                $display("FAIL reset_ctrl: dut%0d got oe,we,busy,done,fault=%b expected 11000", d,
                         {n_oe[d], n_we[d], busy[d], done[d], fault[d]});
            end
            n_cmp++;
            if (oaddr[d] !== 32'h0) begin
                n_bad++; $display("FAIL reset_addr: dut%0d got %h expected 0", d, oaddr[d]);
            end
            n_cmp++;
            if (bus_out[d] !== 32'h0) begin
                n_bad++; $display("FAIL reset_bus_out: dut%0d got %h expected 0", d, bus_out[d]);
            end
            n_cmp++;
            if (rdata[d] !== 32'h0) begin
                n_bad++; $display("FAIL reset_rdata: dut%0d got %h expected 0", d, rdata[d]);
            end
        end
        @(posedge CLK); #1;
        N_RST = 1'b1;
    endtask

    task automatic test_loads;
        run(0, 0, 2'd2, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 32'h10, 32'h0, 2, 1, 0);
        run(0, 0, 2'd0, 1, 32'h13, 32'h0, 32'h80FF1234, 0, 32'hFFFFFF80, 32'h10, 32'h0, 2, 1, 0);
        run(0, 0, 2'd0, 0, 32'h13, 32'h0, 32'h80FF1234, 0, 32'h00000080, 32'h10, 32'h0, 2, 1, 0);
        run(0, 0, 2'd1, 1, 32'h12, 32'h0, 32'h80FF1234, 0, 32'hFFFF80FF, 32'h10, 32'h0, 2, 1, 0);
        run(0, 0, 2'd1, 0, 32'h10, 32'h0, 32'h80FF9234, 0, 32'h00009234, 32'h10, 32'h0, 2, 1, 0);
        run(1, 0, 2'd2, 0, 32'h04, 32'h0, 32'hA5A55A5A, 0, 32'hA5A55A5A, 32'h04, 32'h0, 3, 2, 0);
    endtask

    task automatic test_stores;
        run(1, 1, 2'd1, 0, 32'h22, 32'h0000ABCD, 32'h11223344, 0, 32'h0, 32'h20, 32'hABCD3344, 6, 2, 2);
        run(0, 1, 2'd0, 0, 32'h11, 32'hFFFFFF55, 32'h11223344, 0, 32'h0, 32'h10, 32'h11225544, 4, 1, 1);
        run(0, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0, 32'h0, 32'h40, 32'hCAFEF00D, 3, 0, 1);
        run(1, 1, 2'd2, 0, 32'h44, 32'h0BADF00D, 32'h0, 0, 32'h0, 32'h44, 32'h0BADF00D, 4, 0, 2);
    endtask

    task automatic test_faults;
        run(0, 1, 2'd2, 0, 32'h102, 32'h12345678, 32'h0, 1, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        run(0, 0, 2'd3, 0, 32'h0,   32'h0,        32'h0, 1, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        run(0, 0, 2'd1, 1, 32'h11,  32'h0,        32'h0, 1, 32'h0, 32'h0, 32'h0, 1, 0, 0);
        run(1, 1, 2'd3, 0, 32'h8,   32'h0,        32'h0, 1, 32'h0, 32'h0, 32'h0, 1, 0, 0);
    endtask

    task automatic test_back_to_back;
        int start = done_cnt[0];
        int n;
        push_exp(0, 1, 0, 32'h0, 32'h50, 32'h11111111, 3, 0, 1);
        push_exp(0, 1, 0, 32'h0, 32'h54, 32'h22222222, 3, 0, 1);
        @(posedge CLK); #1;
        set_inputs(0, 1, 2'd2, 0, 32'h50, 32'h11111111);
        req[0] = 1'b1;
        n = 0;
        do begin @(negedge CLK); #1; n++; end while (!busy[0] && n < 10);
        @(posedge CLK); #1;
        set_inputs(0, 1, 2'd2, 0, 32'h54, 32'h22222222);
        n = 0;
        do begin @(negedge CLK); #1; n++; end while (busy[0] && n < 20);
        n_cmp++;
        if (busy[0] !== 1'b0 || done_cnt[0] != start + 1) begin
            n_bad++;
            $display("FAIL b2b_idle_gap: dut0 got busy=%b completions=%0d expected busy=0 completions=%0d",
                     busy[0], done_cnt[0] - start, 1);
        end
        @(posedge CLK); #1;
        req[0] = 1'b0;
        wait_done(0, start + 2, 30);
    endtask

    task automatic test_reset_abort;
        int n = 0;
        @(posedge CLK); #1;
        set_inputs(1, 1, 2'd2, 0, 32'h80, 32'h5A5A5A5A);
        req[1] = 1'b1;
        @(posedge CLK); #1;
        req[1] = 1'b0;
        do begin @(negedge CLK); #2; n++; end while (n_we[1] !== 1'b0 && n < 10);
        n_cmp++;
        if (n_we[1] !== 1'b0) begin
            n_bad++; $display("FAIL abort_setup: dut1 N_WE got %b expected 0", n_we[1]);
        end
        N_RST = 1'b0;
        #1;
        n_cmp++;
        if ({n_we[1], n_oe[1], busy[1], done[1]} !== 4'b1100) begin
            n_bad++;
            $display("FAIL async_abort: dut1 got we,oe,busy,done=%b expected 1100",
                     {n_we[1], n_oe[1], busy[1], done[1]});
        end
        rdata_model[0] = '0;
        rdata_model[1] = '0;
        @(posedge CLK); #1;
        N_RST = 1'b1;
        repeat (2) @(posedge CLK);
        run(1, 0, 2'd1, 0, 32'h32, 32'h0, 32'h12345678, 0, 32'h00001234, 32'h30, 32'h0, 3, 2, 0);
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_back_to_back();
        test_reset_abort();
        repeat (3) @(posedge CLK);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d outstanding expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_master.md
Name: mem_master

Overview:
- Bus initiator for the memory-mapped data path. It drives the ADDR/N_WE/N_OE/IN side of the MMU and reads the MMU's OUT.
- Accepts one CPU load/store request at a time. Sequences the strobes with setup, strobe and hold cycles so the two strobes are never low together.
- Sub-word stores are done as read-modify-write on the 32-bit word. Sub-word loads are extracted and extended.

Parameters:
- READ_WAIT, 1, cycles N_OE is held low before BUS_IN is sampled (>=1).
- WRITE_WAIT, 1, cycles N_WE is held low (>=1).

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- N_RST  in  1  asynchronous, active-low reset.
- REQ  in  1  request strobe; sampled only while BUSY=0.
- WRITE  in  1  1=store, 0=load.
- SIZE  in  2  0=byte, 1=halfword, 2=word; 3 is illegal and treated as FAULT.
- SIGNED  in  1  loads only: sign-extend when 1, zero-extend when 0.
- REQ_ADDR  in  32  byte address.
- WDATA  in  32  store data, right-aligned.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- FAULT  out  1  one-cycle pulse, coincident with DONE, for a misaligned or illegal request.
- RDATA  out  32  load result; valid from DONE until the next accepted request.
- ADDR  out  32  to MMU; REQ_ADDR with bits [1:0] forced to 0.
- N_OE  out  1  to MMU read strobe.
- N_WE  out  1  to MMU write strobe.
- BUS_OUT  out  32  to MMU IN.
- BUS_IN  in  32  from MMU OUT.

Behaviour:
- Outputs:
  - All bus outputs (ADDR, N_OE, N_WE, BUS_OUT) and DONE, FAULT, RDATA come directly from flops; no combinational glitches on strobes.
  - Reset values: N_OE=1, N_WE=1, ADDR=0, BUS_OUT=0, RDATA=0, DONE=0, FAULT=0, BUSY=0, state=IDLE.
- Reset:
  - Asserting N_RST mid-operation aborts immediately. Strobes go high asynchronously and no DONE is produced.
- States: IDLE, RD, WSETUP, WSTROBE, WHOLD, RESP. Wait counter is clog2(max(READ_WAIT,WRITE_WAIT))+1 bits.
- Accept (cycle T):
  - In IDLE with REQ=1, latch WRITE, SIZE, SIGNED, REQ_ADDR, WDATA.
  - Alignment check: half requires addr[0]=0; word requires addr[1:0]=0; SIZE=3 always faults.
  - On failure go to RESP with FAULT=1. No strobe ever asserts and RDATA is unchanged.
- Load:
  - RD for READ_WAIT cycles (T+1..T+READ_WAIT) with N_OE=0.
  - BUS_IN is captured at the edge ending the last RD cycle, then RESP.
  - RESP (T+READ_WAIT+1): N_OE=1, DONE=1, RDATA = selected lane extended per SIGNED.
  - Byte lane = addr[1:0]; byte 0 = bits [7:0]. Half lane = addr[1]; half 0 = bits [15:0].
- Word store:
  - WSETUP 1 cycle: ADDR and BUS_OUT valid, N_WE=1.
  - WSTROBE WRITE_WAIT cycles: N_WE=0.
  - WHOLD 1 cycle: N_WE=1, BUS_OUT and ADDR held, DONE=1.
  - Latency from accept to DONE = WRITE_WAIT+2.
- Sub-word store:
  - Starts with the load RD phase.
  - Captured word merged with WDATA low bits into the addressed lane; other lanes preserved.
  - Then WSETUP (both strobes high, turnaround cycle), WSTROBE, WHOLD with DONE.
  - Latency READ_WAIT+WRITE_WAIT+2.
- Invariants:
  - N_OE and N_WE never both 0.
  - ADDR is stable during any cycle with a strobe low and during the cycles around it.
  - REQ while BUSY=1 is ignored, not queued.
  - REQ in the cycle DONE is high is also ignored; BUSY is still high in RESP/WHOLD.
  - State returns to IDLE the cycle after DONE.

Decomposition:
- Shared package mem_pkg:
  - state enum;
  - SIZE encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the function computing alignment fault.
- One combinational sub-module mem_lane:
  - inputs: word, addr[1:0], SIZE, SIGNED, WDATA;
  - outputs: extracted/extended load value and merged store word.
  - Reused by any future cache or DMA block.

Test Plan:
- Word load with READ_WAIT=1, REQ_ADDR=0x10, BUS_IN=0xDEADBEEF:
  - N_OE low exactly 1 cycle, ADDR=0x10;
  - DONE at T+2 with RDATA=0xDEADBEEF;
  - N_WE stays 1 throughout.
- Signed byte load, REQ_ADDR=0x13, BUS_IN=0x80FF1234 -> RDATA=0xFFFFFF80. Same with SIGNED=0 -> RDATA=0x00000080.
- Halfword store with READ_WAIT=WRITE_WAIT=2, REQ_ADDR=0x22, WDATA=0x0000ABCD, BUS_IN=0x11223344:
  - N_OE low 2 cycles, then 1 cycle with both strobes high;
  - N_WE low 2 cycles with ADDR=0x20 and BUS_OUT=0xABCD3344;
  - DONE 6 cycles after accept.
- Misaligned word store, REQ_ADDR=0x102 -> DONE=FAULT=1 at T+1, N_WE and N_OE never low, RDATA unchanged. SIZE=3 gives the same result.
- Back-to-back: REQ held high continuously for two word writes -> second accepted only in the IDLE cycle after DONE, with no overlapping strobes.
- N_RST asserted while N_WE=0 -> N_WE=1, BUSY=0, DONE=0 before the next clock edge. After release, a new load completes normally.
